// File: rtl/rc_adder_pkg.sv
// Shared types and the round-robin pick helper for the approximate-adder arbiter.
// Default geometry: 16-bit operands, 4 requesters, 5-bit K configuration.
package rc_adder_pkg;

    localparam int RC_W     = 16;
    localparam int RC_N_REQ = 4;
    localparam int RC_KW    = 5;
    localparam int RC_IDW   = $clog2(RC_N_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [RC_W:0]       sum;
        logic [RC_IDW-1:0]   id;
    } res_t;

    typedef struct packed {
        logic                found;
        logic [RC_IDW-1:0]   idx;
    } pick_t;

    // Walks offsets from the highest down so the smallest offset from ptr wins last.
    function automatic pick_t rr_pick(input logic [RC_N_REQ-1:0] valid,
                                      input logic [RC_IDW-1:0]   ptr);
        pick_t p;
        int    j;
        p = '0;
        for (int i = RC_N_REQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % RC_N_REQ;
            if (valid[j]) begin
                p.found = 1'b1;
                p.idx   = RC_IDW'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rc_adder_arbiter_adder.sv
// Combinational W-bit ripple-carry adder whose lowest k cells are approximate:
// an approximate cell outputs a & b & cin and forces its carry-out to 1.
module approx_rc_adder #(
    parameter int W  = 16,
    parameter int KW = 5
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [KW-1:0] k,
    output logic [W:0]    sum
);

    logic [W-1:0] is_apx;

    for (genvar gi = 0; gi < W; gi++) begin : g_cell_mode
        assign is_apx[gi] = (KW'(gi) < k);
    end

    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            if (is_apx[i]) begin
                sum[i] = a[i] & b[i] & carry;
                carry  = 1'b1;
            end else begin
                sum[i] = a[i] ^ b[i] ^ carry;
                carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
            end
        end
        sum[W] = carry;
    end

endmodule

// File: rtl/rc_adder_arbiter.sv
// Round-robin arbiter sharing one approximate adder among N_REQ requesters, one-deep result register.
// Optional error monitor (exact reference adder + statistics) enabled by RC_ARB_ERR_MON_EN.
module rc_adder_arbiter
    import rc_adder_pkg::*;
#(
    parameter int W     = RC_W,
    parameter int N_REQ = RC_N_REQ,
    parameter int KW    = RC_KW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*W-1:0]         req_a,
    input  logic [N_REQ*W-1:0]         req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [W:0]                 res_sum,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    input  logic [KW-1:0]              cfg_k,
    output logic                       busy
`ifdef RC_ARB_ERR_MON_EN
    ,
    input  logic                       err_clr,
    output logic [31:0]                err_acc,
    output logic [W:0]                 err_max,
    output logic [15:0]                err_cnt
`endif
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [KW-1:0] K_MAX = KW'(W);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [KW-1:0]   k_q, k_d;
    res_t            res_q, res_d;

    pick_t           pick;
    logic            accept;
    logic            xfer;
    logic [W-1:0]    a_sel, b_sel;
    logic [W:0]      sum_apx;
    logic [KW-1:0]   k_clamped;

    assign pick      = rr_pick(req_valid, rr_ptr_q);
    assign a_sel     = req_a[pick.idx*W +: W];
    assign b_sel     = req_b[pick.idx*W +: W];
    assign k_clamped = (cfg_k > K_MAX) ? K_MAX : cfg_k;

    approx_rc_adder #(.W(W), .KW(KW)) u_apx (
        .a   (a_sel),
        .b   (b_sel),
        .k   (k_q),
        .sum (sum_apx)
    );

    always_comb begin
        accept    = (state_q == EMPTY) | (res_ready & res_valid);
        req_ready = '0;
        if (accept && pick.found && !rst) begin
            req_ready[pick.idx] = 1'b1;
        end
        xfer = |(req_valid & req_ready);

        state_d  = state_q;
        res_d    = res_q;
        rr_ptr_d = rr_ptr_q;
        k_d      = k_q;
        if (xfer) begin
            state_d   = FULL;
            res_d.sum = sum_apx;
            res_d.id  = pick.idx;
            rr_ptr_d  = (pick.idx == IDW'(N_REQ - 1)) ? '0 : pick.idx + 1'b1;
        end else if (state_q == FULL && res_ready) begin
            state_d = EMPTY;
        end
        // K only changes while idle so a held result always matches the K it was computed with.
        if (state_q == EMPTY && !xfer) begin
            k_d = k_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            res_q    <= '0;
            rr_ptr_q <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            rr_ptr_q <= rr_ptr_d;
            k_q      <= k_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = res_q.sum;
    assign res_id    = res_q.id;
    assign busy      = res_valid;

`ifdef RC_ARB_ERR_MON_EN
    logic [W:0]   sum_exact;
    logic [W:0]   diff;
    logic [32:0]  acc_sum;
    logic [31:0]  err_acc_q;
    logic [W:0]   err_max_q;
    logic [15:0]  err_cnt_q;

    approx_rc_adder #(.W(W), .KW(KW)) u_exact (
        .a   (a_sel),
        .b   (b_sel),
        .k   ('0),
        .sum (sum_exact)
    );

    assign diff    = (sum_apx >= sum_exact) ? (sum_apx - sum_exact) : (sum_exact - sum_apx);
    assign acc_sum = {1'b0, err_acc_q} + 33'(diff);

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_acc_q <= '0;
            err_max_q <= '0;
            err_cnt_q <= '0;
        end else if (xfer) begin
            err_acc_q <= acc_sum[32] ? '1 : acc_sum[31:0];
            if (diff > err_max_q) begin
                err_max_q <= diff;
            end
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign err_acc = err_acc_q;
    assign err_max = err_max_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rc_adder_arbiter.sv
// Directed bench for rc_adder_arbiter: approximate sums, round-robin order, backpressure, reset.
// Error-monitor checks are compiled in when RC_ARB_ERR_MON_EN is defined.
module tb_rc_adder_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [63:0]  req_a;
    logic [63:0]  req_b;
    logic         res_valid;
    logic         res_ready;
    logic [16:0]  res_sum;
    logic [1:0]   res_id;
    logic [4:0]   cfg_k;
    logic         busy;
`ifdef RC_ARB_ERR_MON_EN
    logic         err_clr;
    logic [31:0]  err_acc;
    logic [16:0]  err_max;
    logic [15:0]  err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    rc_adder_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .cfg_k     (cfg_k),
        .busy      (busy)
`ifdef RC_ARB_ERR_MON_EN
        ,
        .err_clr   (err_clr),
        .err_acc   (err_acc),
        .err_max   (err_max),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Idle with res_ready high long enough to drain a held result and then sample cfg_k.
    task automatic set_k(input logic [4:0] k);
        req_valid = '0;
        res_ready = 1'b1;
        cfg_k     = k;
        step();
        step();
    endtask

    // Single-requester handshake; result is left held (res_ready low).
    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] exp, input string tag);
        req_a            = '0;
        req_b            = '0;
        req_a[idx*16 +: 16] = a;
        req_b[idx*16 +: 16] = b;
        req_valid        = 4'b0001 << idx;
        res_ready        = 1'b0;
        #1;
        chk({tag, "_rdy"}, 32'(req_ready), 32'(4'b0001 << idx));
        chk({tag, "_pre"}, 32'(res_valid), 32'd0);
        step();
        req_valid = '0;
        chk({tag, "_vld"}, 32'(res_valid), 32'd1);
        chk({tag, "_sum"}, 32'(res_sum), 32'(exp));
        chk({tag, "_id"},  32'(res_id), 32'(idx));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        cfg_k     = '0;
`ifdef RC_ARB_ERR_MON_EN
        err_clr   = 1'b0;
`endif
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_sum",   32'(res_sum),   32'd0);
        chk("rst_id",    32'(res_id),    32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
`ifdef RC_ARB_ERR_MON_EN
        chk("rst_eacc",  err_acc,        32'd0);
        chk("rst_ecnt",  32'(err_cnt),   32'd0);
`endif
        rst       = 1'b0;
        req_valid = '0;

        set_k(5'd0);
        do_op(0, 16'h0001, 16'h0001, 17'h00002, "k0_1p1");
        chk("busy_full", 32'(busy), 32'd1);

`ifdef RC_ARB_ERR_MON_EN
        err_clr = 1'b1;
`endif
        set_k(5'd15);
`ifdef RC_ARB_ERR_MON_EN
        err_clr = 1'b0;
`endif
        do_op(1, 16'h0001, 16'h0001, 17'h08000, "k15_1p1");
`ifdef RC_ARB_ERR_MON_EN
        chk("err_acc", err_acc,        32'h7FFE);
        chk("err_max", 32'(err_max),   32'h7FFE);
        chk("err_cnt", 32'(err_cnt),   32'd1);
`endif
        set_k(5'd15);
        do_op(2, 16'hFFFF, 16'hFFFF, 17'h1FFFE, "k15_ff");
        set_k(5'd16);
        do_op(3, 16'h0000, 16'h0000, 17'h10000, "k16_0p0");
        set_k(5'd4);
        do_op(0, 16'h00FF, 16'h0001, 17'h00100, "k4_ff");
        set_k(5'd0);
        do_op(1, 16'h1234, 16'h0FFF, 17'h02233, "k0_exact");

        // Reset while FULL, with all requesters pending.
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(i + 1);
            req_b[i*16 +: 16] = 16'h0010;
        end
        req_valid = 4'b1111;
        rst       = 1'b1;
        #1;
        chk("rstf_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        chk("rstf_valid", 32'(res_valid), 32'd0);
        chk("rstf_sum",   32'(res_sum),   32'd0);

        // Streaming: cfg_k changes but is never sampled because every cycle transfers.
        cfg_k     = 5'd15;
        res_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (j % 4)));
            step();
            chk("rr_valid", 32'(res_valid), 32'd1);
            chk("rr_id",    32'(res_id),    32'(j % 4));
            chk("rr_sum",   32'(res_sum),   32'h11 + 32'(j % 4));
        end

        // Backpressure: held result stays put and nobody is granted.
        res_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_id",    32'(res_id),    32'd0);
            chk("bp_sum",   32'(res_sum),   32'h11);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(req_ready), 32'b0010);
        step();
        chk("bp_rel_id",  32'(res_id),    32'd1);
        chk("bp_rel_sum", 32'(res_sum),   32'h12);

        // Consume with no request: result drops, sum holds, pointer stays at 2.
        req_valid = '0;
        step();
        chk("drain_vld",  32'(res_valid), 32'd0);
        chk("drain_sum",  32'(res_sum),   32'h12);
        chk("drain_busy", 32'(busy),      32'd0);
        step();
        req_valid = 4'b1111;
        res_ready = 1'b0;
        #1;
        chk("ptr_hold", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        chk("late_k_id",  32'(res_id),  32'd2);
        chk("late_k_sum", 32'(res_sum), 32'h08000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
